pipeline_control: RTL

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipeline_control.sv
// pipeline_control: stall/flush/enable control for a 5-stage pipe with load-use detection and a multi-cycle mul/div occupancy FSM.
// Optional macro PIPELINE_CONTROL_PERF_CNT_EN adds stall_cycles/flush_events counters.
`ifndef MEM_LOAD
`define MEM_LOAD 2'b01
`endif

module pipeline_control #(
    parameter int LOAD_LATENCY = 1,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_reg_dest,
    input  logic [1:0] ex_mem_type,
    input  logic [4:0] mem_reg_dest,
    input  logic [1:0] mem_mem_type,
    input  logic [1:0] ex_md_op,
    input  logic       mem_stall,
    input  logic       exception_flush,
    input  logic       branch_flush,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       md_busy,
    output logic       md_done
`ifdef PIPELINE_CONTROL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);
    localparam int MAXC = DIV_CYCLES > MUL_CYCLES ? DIV_CYCLES : MUL_CYCLES;
    localparam int CW = $clog2(MAXC);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t      state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  md_ld;
    logic           md_start;
    logic           ex_hit;
    logic           mem_hit;
    logic           load_use;

    assign ex_hit = ex_mem_type == `MEM_LOAD && ex_reg_dest != 5'd0 &&
                    ((id_use_rs && id_rs == ex_reg_dest) || (id_use_rt && id_rt == ex_reg_dest));
    assign mem_hit = mem_mem_type == `MEM_LOAD && mem_reg_dest != 5'd0 &&
                     ((id_use_rs && id_rs == mem_reg_dest) || (id_use_rt && id_rt == mem_reg_dest));
    assign load_use = ex_hit || (LOAD_LATENCY == 2 && mem_hit);
    assign md_start = ex_md_op == 2'b01 || ex_md_op == 2'b10;
    assign md_ld = ex_md_op == 2'b01 ? CW'(MUL_CYCLES - 2) : CW'(DIV_CYCLES - 2);
    assign md_busy = state == BUSY;
    assign md_done = state == DONE;

    // Mul/div occupancy: the busy phase lasts (cycles-2) so start + busy + done spans the full op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else if (!mem_stall && exception_flush) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            case (state)
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: if (!mem_stall) begin
                    state <= md_start ? (md_ld == '0 ? DONE : BUSY) : IDLE;
                    cnt <= md_start ? md_ld : '0;
                end
                default: if (md_start && !mem_stall) begin
                    state <= md_ld == '0 ? DONE : BUSY;
                    cnt <= md_ld;
                end
            endcase
        end
    end

    // Stage control: freeze > exception > mul/div stall > load-use stall > branch redirect
    always_comb begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b000;
        if (mem_stall) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
        end else if (exception_flush) begin
            {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
        end else if (md_busy) begin
            {pc_en, if_id_en, id_ex_en} = 3'b000;
            ex_mem_flush = 1'b1;
        end else if (load_use) begin
            {pc_en, if_id_en} = 2'b00;
            id_ex_flush = 1'b1;
        end else if (branch_flush) begin
            if_id_flush = 1'b1;
        end
    end

`ifdef PIPELINE_CONTROL_PERF_CNT_EN
    // Free-running event counters, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, ~pc_en};
            flush_events <= flush_events + {31'd0, if_id_flush | id_ex_flush | ex_mem_flush};
        end
    end
`endif
endmodule
